// File: rtl/conv_scan_ctrl.sv
// Scan sequencer for the 3x3 conv array: loads kernel taps from the weight banks, then walks x/y/X/Y.
// Build option CONV_SCAN_STALL_EN adds a stall input that freezes the SCAN phase.
module conv_scan_ctrl #(
    parameter int KW     = 3,
    parameter int OW     = 19,
    parameter int AW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          xrst,
    input  logic          start,
`ifdef CONV_SCAN_STALL_EN
    input  logic          stall,
`endif
    output logic          busy,
    output logic          finish,
    output logic [AW-1:0] raddr,
    output logic          w_load,
    output logic [AW-1:0] w_tap,
    output logic [1:0]    x,
    output logic [1:0]    y,
    output logic [4:0]    X,
    output logic [4:0]    Y,
    output logic          x_adv,
    output logic          y_adv,
    output logic          x_wrap,
    output logic          scan_vld,
    output logic [1:0]    dbg_state
);

    localparam int NTAP     = KW * KW;
    localparam int LOAD_LEN = NTAP + RD_LAT;
    localparam int CW       = $clog2(LOAD_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                     r_state;
    logic [CW-1:0]              r_cnt;
    logic [AW-1:0]              r_raddr;
    logic [1:0]                 r_x;
    logic [1:0]                 r_y;
    logic [4:0]                 r_X;
    logic [4:0]                 r_Y;
    logic [RD_LAT-1:0]          r_pipe_vld;
    logic [RD_LAT-1:0][AW-1:0]  r_pipe_tap;

    logic w_stall;
    logic w_step;
    logic w_issue;
    logic w_x_last;
    logic w_y_last;
    logic w_X_last;
    logic w_Y_last;

`ifdef CONV_SCAN_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_step   = (r_state == S_SCAN) && !w_stall;
    assign w_issue  = (r_state == S_LOAD) && (r_cnt < CW'(NTAP));
    assign w_x_last = (r_x == 2'(KW - 1));
    assign w_y_last = (r_y == 2'(KW - 1));
    assign w_X_last = (r_X == 5'(OW - 1));
    assign w_Y_last = (r_Y == 5'(OW - 1));

    // raddr is the tap issued this cycle; it returns to 0 once the last tap has been issued.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_raddr <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_X     <= '0;
            r_Y     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_raddr <= '0;
                    end
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt < CW'(NTAP - 1)) begin
                        r_raddr <= r_raddr + 1'b1;
                    end else begin
                        r_raddr <= '0;
                    end
                    if (r_cnt == CW'(LOAD_LEN - 1)) begin
                        r_state <= S_SCAN;
                        r_cnt   <= '0;
                    end
                end
                S_SCAN: begin
                    if (!w_stall) begin
                        if (!w_x_last) begin
                            r_x <= r_x + 1'b1;
                        end else begin
                            r_x <= '0;
                            if (!w_y_last) begin
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_y <= '0;
                                if (!w_X_last) begin
                                    r_X <= r_X + 1'b1;
                                end else begin
                                    r_X <= '0;
                                    if (!w_Y_last) begin
                                        r_Y <= r_Y + 1'b1;
                                    end else begin
                                        r_Y     <= '0;
                                        r_state <= S_DONE;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-latency shift pipeline; the tap travels with its valid so w_tap matches rdata.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_pipe_vld <= '0;
            r_pipe_tap <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_tap[0] <= w_issue ? r_raddr : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tap[i] <= r_pipe_tap[i-1];
            end
        end
    end

    assign busy      = (r_state == S_LOAD) || (r_state == S_SCAN);
    assign finish    = (r_state == S_DONE);
    assign raddr     = r_raddr;
    assign w_load    = r_pipe_vld[RD_LAT-1];
    assign w_tap     = r_pipe_tap[RD_LAT-1];
    assign x         = r_x;
    assign y         = r_y;
    assign X         = r_X;
    assign Y         = r_Y;
    assign scan_vld  = w_step;
    assign x_adv     = w_step && !w_x_last;
    assign y_adv     = w_step && w_x_last && !w_y_last;
    assign x_wrap    = w_step && w_x_last && w_X_last;
    assign dbg_state = r_state;

endmodule
